// File: rtl/leiwand_rv32_wait_mem.sv
// Word-addressed RAM on the rv32 valid/ready bus with base/size decode,
// configurable read/write wait states and an error response for bad addresses.
module leiwand_rv32_wait_mem #(
   parameter int unsigned WORDS         = 4096,
   parameter logic [31:0] BASE_ADDR     = 32'h20400000,
   parameter int unsigned READ_LATENCY  = 1,
   parameter int unsigned WRITE_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid,
   output logic        ready,
   output logic        error,
   input  logic [3:0]  wen,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata
);

   localparam int unsigned IW       = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'(WORDS) << 2);
   localparam logic [3:0]  RLAT_M1  = 4'(READ_LATENCY - 1);
   localparam logic [3:0]  WLAT_M1  = 4'(WRITE_LATENCY - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_ERR} state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [3:0]    wen_q, wen_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   rdata_q, rdata_d;

   logic [31:0]   mem [0:WORDS-1];

   logic          hit, mis;
   logic [3:0]    lat_m1;
   logic [IW-1:0] req_idx;
   logic          commit;
   logic [IW-1:0] c_idx;
   logic [3:0]    c_wen;
   logic [31:0]   c_wdata;

   always_comb begin
      hit     = ({1'b0, addr} >= {1'b0, BASE_ADDR}) && ({1'b0, addr} < END_ADDR);
      mis     = (addr[1:0] != 2'b00);
      // BASE_ADDR is word aligned, so the word offset is a plain subtraction of the index bits
      req_idx = addr[IW+1:2] - BASE_ADDR[IW+1:2];
      lat_m1  = (wen != 4'b0000) ? WLAT_M1 : RLAT_M1;

      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wen_d   = wen_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      commit  = 1'b0;
      c_idx   = idx_q;
      c_wen   = wen_q;
      c_wdata = wdata_q;

      unique case (state_q)
         S_IDLE: begin
            if (valid) begin
               idx_d   = req_idx;
               wen_d   = wen;
               wdata_d = wdata;
               if (!hit || mis) begin
                  state_d = S_ERR;
                  rdata_d = '0;
               end else begin
                  cnt_d = lat_m1;
                  if (lat_m1 == 4'd0) begin
                     // single-cycle access commits straight from the live request
                     state_d = S_RESP;
                     commit  = 1'b1;
                     c_idx   = req_idx;
                     c_wen   = wen;
                     c_wdata = wdata;
                  end else begin
                     state_d = S_WAIT;
                  end
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = S_RESP;
               commit  = 1'b1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (commit) begin
         rdata_d = mem[c_idx];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wen_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wen_q   <= wen_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // array has no reset; a held reset must still block the commit
   always_ff @(posedge clk) begin
      if (reset && commit) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (c_wen[i]) begin
               mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
            end
         end
      end
   end

   assign ready = (state_q == S_RESP) || (state_q == S_ERR);
   assign error = (state_q == S_ERR);
   assign rdata = rdata_q;

endmodule

// File: tb/tb_leiwand_rv32_wait_mem.sv
// Bench for leiwand_rv32_wait_mem: a fast (1/1) and a slow (3/4) instance,
// directed vectors, a mid-transaction reset and randomized traffic vs a model.
module tb_leiwand_rv32_wait_mem;

   localparam logic [31:0] BASE  = 32'h20400000;
   localparam int          WORDS = 4096;
   localparam int          RL_S  = 3;
   localparam int          WL_S  = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_f = 1'b0, valid_s = 1'b0;
   logic [31:0] addr = '0, wdata = '0;
   logic [3:0]  wen = '0;
   logic        ready_f, error_f, ready_s, error_s;
   logic [31:0] rdata_f, rdata_s;

   always #5 clk = ~clk;

   leiwand_rv32_wait_mem #(
      .WORDS(WORDS), .BASE_ADDR(BASE), .READ_LATENCY(1), .WRITE_LATENCY(1)
   ) u_fast (
      .clk(clk), .reset(rst_n), .valid(valid_f), .ready(ready_f), .error(error_f),
      .wen(wen), .addr(addr), .wdata(wdata), .rdata(rdata_f)
   );

   leiwand_rv32_wait_mem #(
      .WORDS(WORDS), .BASE_ADDR(BASE), .READ_LATENCY(RL_S), .WRITE_LATENCY(WL_S)
   ) u_slow (
      .clk(clk), .reset(rst_n), .valid(valid_s), .ready(ready_s), .error(error_s),
      .wen(wen), .addr(addr), .wdata(wdata), .rdata(rdata_s)
   );

   int tests = 0;
   int fails = 0;
   logic [31:0] mf[int];
   logic [31:0] ms[int];
   bit ph = 1'b0;
   bit ps = 1'b0;

   typedef struct {
      bit          s;
      logic [31:0] a;
      logic [3:0]  w;
      logic [31:0] d;
      int          lat;
      bit          e;
      logic [31:0] r;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic preload(input bit s, input logic [11:0] idx, input logic [31:0] v);
      if (s) begin
         u_slow.mem[idx] = v;
         ms[int'(idx)] = v;
      end else begin
         u_fast.mem[idx] = v;
         mf[int'(idx)] = v;
      end
   endtask

   // Reference: decode, old-word response, byte-lane merge, latency by access kind
   task automatic model(input bit s, input logic [31:0] a, input logic [3:0] w,
                        input logic [31:0] d, output int lat, output bit e,
                        output logic [31:0] r);
      longint la = longint'(a);
      longint lo = longint'(BASE);
      longint hi = lo + 4 * WORDS;
      logic [31:0] word;
      int idx;
      if (la < lo || la >= hi || a[1:0] != 2'b00) begin
         lat = 1; e = 1'b1; r = '0;
      end else begin
         idx  = int'((la - lo) / 4);
         word = s ? ms[idx] : mf[idx];
         r    = word;
         e    = 1'b0;
         if (w != 4'b0000) lat = s ? WL_S : 1;
         else              lat = s ? RL_S : 1;
         for (int i = 0; i < 4; i++)
            if (w[i]) word[8*i +: 8] = d[8*i +: 8];
         if (s) ms[idx] = word; else mf[idx] = word;
      end
   endtask

   // Called at a negedge; returns cycles from valid raise to ready (-1 on timeout)
   task automatic txn(input bit s, input logic [31:0] a, input logic [3:0] w,
                      input logic [31:0] d, input bit hold, input string tag,
                      output int k, output bit e, output logic [31:0] r);
      valid_f = !s;
      valid_s = s;
      addr    = a;
      wen     = w;
      wdata   = d;
      k = -1; e = 1'b0; r = '0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (s ? ready_s : ready_f) begin
            k = c;
            e = s ? error_s : error_f;
            r = s ? rdata_s : rdata_f;
            break;
         end
      end
      if (!hold || k < 0) begin
         valid_f = 1'b0;
         valid_s = 1'b0;
         @(negedge clk);
         chk({tag, " pulse"}, {31'b0, (s ? ready_s : ready_f)}, 32'd0);
      end
   endtask

   task automatic run(input bit s, input logic [31:0] a, input logic [3:0] w,
                      input logic [31:0] d, input bit hold, input string tag,
                      input int lat, input bit e, input logic [31:0] r);
      int k;
      bit ge;
      logic [31:0] gr;
      int extra;
      extra = (ph && ps == s) ? 1 : 0;
      txn(s, a, w, d, hold, tag, k, ge, gr);
      chk({tag, " lat"}, 32'(k), 32'(lat + extra));
      chk({tag, " err"}, {31'b0, ge}, {31'b0, e});
      chk({tag, " rdata"}, gr, r);
      ph = hold && (k >= 0);
      ps = s;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int lat;
      bit e;
      logic [31:0] r;
      logic [31:0] a, d;
      logic [3:0] w;
      bit s, hold;
      int sel;

      repeat (3) @(negedge clk);
      chk("rst ready_f", {31'b0, ready_f}, 32'd0);
      chk("rst error_f", {31'b0, error_f}, 32'd0);
      chk("rst rdata_f", rdata_f, 32'd0);
      chk("rst ready_s", {31'b0, ready_s}, 32'd0);
      chk("rst error_s", {31'b0, error_s}, 32'd0);
      chk("rst rdata_s", rdata_s, 32'd0);

      for (int i = 0; i < 32; i++) begin
         preload(1'b0, 12'(i), $urandom);
         preload(1'b1, 12'(i), $urandom);
      end
      preload(1'b0, 12'd4095, 32'hCAFEF00D);
      preload(1'b1, 12'd4095, $urandom);
      preload(1'b0, 12'd0, 32'hDEADBEEF);
      preload(1'b0, 12'd2, 32'hAABBCCDD);
      preload(1'b1, 12'd0, 32'h00000000);
      preload(1'b1, 12'd4, 32'h00000000);
      preload(1'b1, 12'd5, 32'h12345678);

      rst_n = 1'b1;
      @(negedge clk);

      tbl.push_back('{1'b0, 32'h20400000, 4'b0000, 32'h0,        1, 1'b0, 32'hDEADBEEF});
      tbl.push_back('{1'b1, 32'h20400014, 4'b0000, 32'h0,        3, 1'b0, 32'h12345678});
      tbl.push_back('{1'b0, 32'h20400008, 4'b0101, 32'h11223344, 1, 1'b0, 32'hAABBCCDD});
      tbl.push_back('{1'b0, 32'h20400008, 4'b0000, 32'h0,        1, 1'b0, 32'hAA22CC44});
      tbl.push_back('{1'b0, 32'h20404000, 4'b0000, 32'h0,        1, 1'b1, 32'h0});
      tbl.push_back('{1'b0, 32'h203FFFFC, 4'b0000, 32'h0,        1, 1'b1, 32'h0});
      tbl.push_back('{1'b0, 32'h20400002, 4'b0000, 32'h0,        1, 1'b1, 32'h0});
      tbl.push_back('{1'b0, 32'h20404000, 4'b1111, 32'h55555555, 1, 1'b1, 32'h0});
      tbl.push_back('{1'b0, 32'h20400000, 4'b0000, 32'h0,        1, 1'b0, 32'hDEADBEEF});
      tbl.push_back('{1'b0, 32'h20403FFC, 4'b0000, 32'h0,        1, 1'b0, 32'hCAFEF00D});
      tbl.push_back('{1'b1, 32'h20400010, 4'b1111, 32'h01020304, 4, 1'b0, 32'h00000000});
      tbl.push_back('{1'b1, 32'h20400010, 4'b0000, 32'h0,        3, 1'b0, 32'h01020304});
      tbl.push_back('{1'b1, 32'h20404000, 4'b0000, 32'h0,        1, 1'b1, 32'h0});
      tbl.push_back('{1'b1, 32'h20400002, 4'b1111, 32'hFFFFFFFF, 1, 1'b1, 32'h0});
      tbl.push_back('{1'b1, 32'h20400000, 4'b0000, 32'h0,        3, 1'b0, 32'h00000000});

      foreach (tbl[i]) begin
         model(tbl[i].s, tbl[i].a, tbl[i].w, tbl[i].d, lat, e, r);
         run(tbl[i].s, tbl[i].a, tbl[i].w, tbl[i].d, 1'b0, $sformatf("vec%0d", i),
             tbl[i].lat, tbl[i].e, tbl[i].r);
      end

      // write aborted by reset while waiting
      preload(1'b1, 12'd1, 32'h00000000);
      valid_s = 1'b1;
      addr    = 32'h20400004;
      wen     = 4'b1111;
      wdata   = 32'hFFFFFFFF;
      @(negedge clk);
      chk("abort ready1", {31'b0, ready_s}, 32'd0);
      @(negedge clk);
      chk("abort ready2", {31'b0, ready_s}, 32'd0);
      rst_n = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("abort ready_rst", {31'b0, ready_s}, 32'd0);
         chk("abort rdata_rst", rdata_s, 32'd0);
      end
      valid_s = 1'b0;
      rst_n   = 1'b1;
      @(negedge clk);
      chk("abort mem1", u_slow.mem[1], 32'h00000000);
      run(1'b1, 32'h20400004, 4'b0000, 32'h0, 1'b0, "abort read", RL_S, 1'b0, 32'h0);

      // 8 back-to-back alternating write/read on the slow instance
      for (int i = 0; i < 8; i++) begin
         a = BASE + 32'(4 * $urandom_range(0, 31));
         w = (i % 2 == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
         d = $urandom;
         model(1'b1, a, w, d, lat, e, r);
         run(1'b1, a, w, d, (i != 7), $sformatf("b2b%0d", i), lat, e, r);
      end

      // randomized traffic on both instances
      for (int n = 0; n < 100; n++) begin
         s   = 1'($urandom_range(0, 1));
         sel = $urandom_range(0, 9);
         if (sel < 7)       a = BASE + 32'(4 * $urandom_range(0, 31));
         else if (sel == 7) a = BASE + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(1, 3));
         else if (sel == 8) a = ($urandom_range(0, 1) != 0) ? BASE + 32'(4 * WORDS) : BASE - 32'd4;
         else               a = BASE + 32'(4 * (WORDS - 1));
         w    = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
         d    = $urandom;
         hold = (n != 99) && ($urandom_range(0, 1) != 0);
         model(s, a, w, d, lat, e, r);
         run(s, a, w, d, hold, $sformatf("rnd%0d", n), lat, e, r);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/leiwand_rv32_wait_mem.md
Name: leiwand_rv32_wait_mem

Overview:
- Parametrised successor to the single-cycle simple memory used behind the rv32 core's valid/ready memory bus.
- Adds internal base/size address decode, so no external range gating is needed.
- Adds configurable read and write wait states, which lets SoC and core benches model slow ROM/RAM.
- Adds an error response for out-of-range and misaligned accesses.
- Byte-lane writes; memory contents remain preloadable by hierarchical access to mem[].

Parameters:
- WORDS, 4096, number of 32-bit words in the array; must be ≥ 1.
- BASE_ADDR, 32'h20400000, byte address of word 0; must be 4-byte aligned.
- READ_LATENCY, 1, accept-edge-to-ready cycles for reads; range 1..15.
- WRITE_LATENCY, 1, accept-edge-to-ready cycles for writes; range 1..15.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset
- valid  input  1  request from master; held until ready
- ready  output  1  one-cycle completion pulse
- error  output  1  qualifies ready; access rejected
- wen  input  4  byte write enables; 0 means read; bit i covers wdata[8i+7:8i]
- addr  input  32  byte address
- wdata  input  32  write data
- rdata  output  32  read data, valid while ready=1

Behaviour:
- Interface is fixed: one clock (clk); reset is asynchronous and active-low.
- Reset values: ready=0, error=0, rdata=0, FSM=IDLE, wait counter=0.
- mem[] is not cleared by reset.

FSM states:
- IDLE: on a clk edge with valid=1, capture addr, wen and wdata.
  - Compute hit = (addr ≥ BASE_ADDR) && (addr < BASE_ADDR+4*WORDS), using 33-bit arithmetic so no wrap occurs.
  - Compute mis = (addr[1:0] != 0).
  - If !hit or mis, go to ERR.
  - Otherwise load cnt = LAT-1, where LAT = (wen != 0) ? WRITE_LATENCY : READ_LATENCY. Go to RESP if LAT==1, else WAIT.
- WAIT: decrement cnt each edge. Go to RESP on the edge where cnt==1.
- RESP: ready=1 for exactly one cycle, error=0.
  - rdata = mem[(addr-BASE_ADDR)>>2] as it was before this transaction's write.
  - Write lanes with wen[i]=1 commit on the edge that enters RESP.
  - Next state is IDLE.
- ERR: ready=1 and error=1 for exactly one cycle, rdata=0, no array write. Next state is IDLE.
  - Error latency is always 1 cycle, regardless of the latency parameters.

Handshake and timing:
- Latency: ready is high in cycle N+LAT, where N is the accept edge. READ_LATENCY=1 therefore matches legacy simple_mem timing.
- Master drops valid (or presents a new request) on the edge at which it sees ready. A new request is accepted only in IDLE, so there is a minimum one-cycle gap between accept edges (back-to-back throughput is 1 per LAT+1 cycles).
- valid, addr, wen and wdata are ignored outside IDLE; captured values are used for the whole transaction.
- rdata holds its last value while ready=0; it is undefined to the master.
- Reset asserted during WAIT: the transaction is aborted, no write is committed, and ready never pulses. Reset asserted on/after the RESP-entry edge: the write stays committed.
- Highest word (BASE_ADDR+4*WORDS-4) is a hit. BASE_ADDR+4*WORDS is an error.

Test Plan:
- Preload mem[0]=32'hDEADBEEF; READ_LATENCY=1; read addr 32'h20400000 → ready one cycle after accept, rdata=32'hDEADBEEF, error=0.
- READ_LATENCY=3; read mem[5]=32'h12345678 at 32'h20400014 → ready in cycle N+3 only, rdata=32'h12345678.
- mem[2]=32'hAABBCCDD; write 32'h11223344 with wen=4'b0101 at 32'h20400008 → RESP rdata=32'hAABBCCDD; subsequent read returns 32'hAA22CC44.
- Read 32'h20404000 (WORDS=4096), 32'h203FFFFC and 32'h20400002 → each gives ready=1, error=1, rdata=0 one cycle after accept; write to 32'h20404000 leaves memory unchanged.
- WRITE_LATENCY=4; write mem[1]=0 with 32'hFFFFFFFF; assert reset low two cycles after accept → no ready, mem[1] stays 0; after reset, a read of mem[1] returns 0.
- Master reissues valid immediately after each ready for 8 alternating read/write transactions → each completes exactly once, no double accept, data matches the reference model.
